// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the mem_arbiter block.
// Arbitration mode is selected by MEM_ARB_FIXED_PRIO_EN (see rr_arbiter / mem_arbiter).
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 4;
  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned NUM_REQ_DEFAULT = 2;
  localparam int unsigned NUM_REQ_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP
  } state_e;

  // Sized for the largest supported requester count so one type serves every build.
  typedef logic [$clog2(NUM_REQ_MAX)-1:0] owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter side; master = environment side (requesters plus the memory).
interface mem_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [ADDR_W-1:0]         addr;
  logic                      wr_en;
  logic                      rd_en;
  logic [DATA_W-1:0]         wdata;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rdata,
    output req_ready, rsp_valid, rsp_rdata, addr, wr_en, rd_en, wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rdata,
    input  req_ready, rsp_valid, rsp_rdata, addr, wr_en, rd_en, wdata, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant. Round-robin from last_grant_i+1 by default;
// MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, no pointer input).
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  owner_t             last_grant_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  // Visit candidates in order last+1, last+2, ... wrapping modulo NUM_REQ.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && ((32'(last_grant_i) + 32'd1 + k) % NUM_REQ) == i) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory among NUM_REQ valid/ready requesters, one operation in flight.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority; default build is round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
  input logic       clk,
  input logic       reset,
  mem_arb_if.slave  bus
);

  state_e              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  gnt;
  owner_t              gnt_idx;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic                gnt_we;
  logic [NUM_REQ-1:0]  owner_oh;

`ifndef MEM_ARB_FIXED_PRIO_EN
  owner_t              last_grant_q, last_grant_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i        (bus.req_valid),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_o        (gnt)
  );

  // Select the winner's request fields from the flattened buses.
  always_comb begin
    gnt_idx   = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = owner_t'(i);
        gnt_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        gnt_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        gnt_we    = bus.req_we[i];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == owner_t'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        // The memory-side address/data registers double as the request latch.
        if (|gnt) begin
          owner_d = gnt_idx;
          addr_d  = gnt_addr;
          wdata_d = gnt_wdata;
          wr_en_d = gnt_we;
          rd_en_d = !gnt_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_en_q) begin
          rsp_valid_d = owner_oh;
          state_d     = RESP;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        rsp_rdata_d = bus.rdata;
        rsp_valid_d = owner_oh;
        state_d     = RESP;
      end
      RESP: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_grant_d = owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Reset to the top index so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= owner_t'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
